// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: data pattern selector and FSM states.
package mem_fill_pkg;

  localparam int unsigned FillModeW = 2;

  typedef enum logic [FillModeW-1:0] {
    ModeIdentity = 2'd0,
    ModeConst    = 2'd1,
    ModeRamp     = 2'd2,
    ModeDescend  = 2'd3
  } fill_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_t;

endpackage

// File: rtl/mem_fill_datagen.sv
// Pattern generator: latches mode/seed/step at load and produces the data word for write k=count.
module mem_fill_datagen
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [DATA_W-1:0] data_o
);

  fill_mode_t        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] acc_q;
  logic [31:0]       desc;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= ModeIdentity;
      seed_q <= '0;
      step_q <= '0;
      acc_q  <= '0;
    end else if (load_i) begin
      mode_q <= fill_mode_t'(mode_i);
      seed_q <= seed_i;
      step_q <= step_i;
      acc_q  <= seed_i;
    end else if (advance_i) begin
      // Accumulator tracks seed + k*step; it only moves on an accepted write.
      acc_q <= acc_q + step_q;
    end
  end

  assign desc = DEPTH - 32'd1 - 32'(count_i);

  always_comb begin
    data_o = '0;
    unique case (mode_q)
      ModeIdentity: data_o = DATA_W'(count_i);
      ModeConst:    data_o = seed_q;
      ModeRamp:     data_o = acc_q;
      ModeDescend:  data_o = DATA_W'(desc);
      default:      data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_fill.sv
// RAM initialiser: writes DEPTH patterned words at one per clock after start.
// Optional MEM_FILL_STALL_EN adds a stall input that pauses the fill without losing position.
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MEM_FILL_STALL_EN
  input  logic              stall,
`endif
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] step,
  input  logic              ack,
  output logic              busy,
  output logic              finish,
  output logic              write_en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned   CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DEPTH - 1);

  if (DEPTH < 1 || DEPTH > (32'd1 << ADDR_W)) begin : g_depth_check
    $error("mem_fill: DEPTH must be in 1..2**ADDR_W");
  end

  state_t            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              stall_w;
  logic              load;
  logic              advance;
  logic [DATA_W-1:0] gen_data;

`ifdef MEM_FILL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          count_d = '0;
          load    = 1'b1;
        end
      end
      StFill: begin
        if (!stall_w) begin
          advance = 1'b1;
          // count parks on the last address so DONE reports it without extra state.
          if (count_q == LastCnt) begin
            state_d = StDone;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (ack) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  mem_fill_datagen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_datagen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .advance_i(advance),
    .mode_i   (mode),
    .seed_i   (seed),
    .step_i   (step),
    .count_i  (count_q),
    .data_o   (gen_data)
  );

  assign busy     = (state_q == StFill);
  assign finish   = (state_q == StDone);
  assign write_en = busy & ~stall_w;
  assign address  = count_q[ADDR_W-1:0];
  assign data     = write_en ? gen_data : '0;

endmodule
